// File: rtl/tick_timer_sched.sv
// Shared seconds-timer: round-robin arbitration among N requesters, loads the winner's
// duration and counts it down on an internal 1 Hz enable, pulsing done on expiry.
module tick_timer_sched #(
    parameter int N      = 4,
    parameter int SECS_W = 8,
    parameter int DIV    = 50000000,
    localparam int OW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N*SECS_W-1:0]   req_secs,
    input  logic [N-1:0]          abort,
    output logic [N-1:0]          grant,
    output logic [N-1:0]          done,
    output logic                  busy,
    output logic [OW-1:0]         owner,
    output logic [SECS_W-1:0]     remaining,
    output logic                  tick_1hz
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, EXPIRE} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     presc;
    logic [OW-1:0]     rr_ptr;
    logic              win_found;
    logic [OW-1:0]     win_idx;
    logic [SECS_W-1:0] win_secs;
    logic [OW:0]       idx_sum;
    logic              aborting;

    // Rotating priority scan starting at rr_ptr, wrapping at N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_sum   = '0;
        for (int k = 0; k < N; k++) begin
            idx_sum = {1'b0, rr_ptr} + (OW+1)'(k);
            if (idx_sum >= (OW+1)'(N))
                idx_sum = idx_sum - (OW+1)'(N);
            if (!win_found && req[idx_sum[OW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx_sum[OW-1:0];
            end
        end
        win_secs = '0;
        for (int i = 0; i < N; i++)
            if (OW'(i) == win_idx)
                win_secs = req_secs[i*SECS_W +: SECS_W];
    end

    assign tick_1hz = (state == COUNT) && (presc == PW'(DIV - 1));
    assign aborting = (state == COUNT) && abort[owner];
    assign busy     = (state == COUNT);
    assign done     = (state == EXPIRE) ? (N'(1) << owner) : '0;

    // A zero-length interval still spends its grant cycle in COUNT (remaining==0) so
    // that done lands one cycle after grant and never coincides with it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = COUNT;
            COUNT: begin
                if (aborting)
                    state_nxt = IDLE;
                else if (remaining == '0 || (tick_1hz && remaining == SECS_W'(1)))
                    state_nxt = EXPIRE;
            end
            EXPIRE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant     <= '0;
            owner     <= '0;
            remaining <= '0;
            presc     <= '0;
            rr_ptr    <= '0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    presc <= '0;
                    if (win_found) begin
                        grant     <= N'(1) << win_idx;
                        owner     <= win_idx;
                        remaining <= win_secs;
                        rr_ptr    <= (win_idx == OW'(N - 1)) ? '0 : win_idx + OW'(1);
                    end
                end
                COUNT: begin
                    if (aborting) begin
                        remaining <= '0;
                        presc     <= '0;
                    end else begin
                        presc <= tick_1hz ? '0 : presc + PW'(1);
                        if (tick_1hz && remaining != '0)
                            remaining <= remaining - SECS_W'(1);
                    end
                end
                default: begin
                    remaining <= '0;
                    presc     <= '0;
                end
            endcase
        end
    end
endmodule
